// File: rtl/div_16bit_seq.sv
// Sequential unsigned restoring divider: one quotient bit per clock, quotient/remainder
// registered on completion, with a divide-by-zero short path that skips iteration.
//
// state | meaning
// IDLE  | waiting for START; outputs hold the last result
// CALC  | one restoring step per clock, N steps total
// FIM   | results valid, DONE pulse for one cycle
module div_16bit_seq #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         START,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic [N-1:0] QUOCIENTE,
    output logic [N-1:0] RESTO,
    output logic         BUSY,
    output logic         DONE,
    output logic         DIV_ZERO
);

    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIM  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;

    logic [N-1:0]  q_sh;
    logic [N-1:0]  r_part;
    logic [N-1:0]  divisor;
    logic [CW-1:0] cnt;

    logic [N:0]    trial;
    logic [N:0]    diff;
    logic          no_borrow;
    logic [N-1:0]  q_step;
    logic [N-1:0]  r_step;
    logic          last_step;
    logic          divisor_zero;

    // Partial remainder stays below the divisor, so the N+1-bit difference never overflows
    // and its MSB is a valid sign/borrow bit.
    always_comb begin
        trial     = {r_part, q_sh[N-1]};
        diff      = trial - {1'b0, divisor};
        no_borrow = ~diff[N];
        r_step    = no_borrow ? diff[N-1:0] : trial[N-1:0];
        q_step    = {q_sh[N-2:0], no_borrow};
        last_step = (cnt == CW'(N - 1));
    end

    assign divisor_zero = (B == '0);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (START) begin
                    state_nxt = divisor_zero ? FIM : CALC;
                end
            end
            CALC: begin
                if (last_step) begin
                    state_nxt = FIM;
                end
            end
            FIM:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_sh      <= '0;
            r_part    <= '0;
            divisor   <= '0;
            cnt       <= '0;
            QUOCIENTE <= '0;
            RESTO     <= '0;
            DIV_ZERO  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (START) begin
                        q_sh    <= A;
                        divisor <= B;
                        r_part  <= '0;
                        cnt     <= '0;
                        if (divisor_zero) begin
                            QUOCIENTE <= '1;
                            RESTO     <= A;
                            DIV_ZERO  <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    q_sh   <= q_step;
                    r_part <= r_step;
                    cnt    <= cnt + CW'(1);
                    if (last_step) begin
                        QUOCIENTE <= q_step;
                        RESTO     <= r_step;
                        DIV_ZERO  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign BUSY = (state == CALC);
    assign DONE = (state == FIM);

endmodule

// File: tb/tb_div_16bit_seq.sv
// Directed and swept checks for div_16bit_seq: latency, flags, results, back-to-back
// issue with START held, mid-operation reset.
module tb_div_16bit_seq;

    logic        clk;
    logic        rst_n;
    logic        START;
    logic [15:0] A;
    logic [15:0] B;
    logic [15:0] QUOCIENTE;
    logic [15:0] RESTO;
    logic        BUSY;
    logic        DONE;
    logic        DIV_ZERO;

    int n_vec = 0;
    int n_err = 0;

    div_16bit_seq #(.N(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .START     (START),
        .A         (A),
        .B         (B),
        .QUOCIENTE (QUOCIENTE),
        .RESTO     (RESTO),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .DIV_ZERO  (DIV_ZERO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] q;
        logic [15:0] r;
        logic        dz;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_done(input int limit, output int n);
        n = 0;
        while (DONE !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Called at a negedge in IDLE; returns at the negedge following the FIM cycle.
    task automatic do_op(input string name, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] eq, input logic [15:0] er, input logic edz);
        int          cyc;
        int          busy_cnt;
        bit          seen;
        bit          stable;
        logic [15:0] q_prev;
        logic [15:0] r_prev;
        logic        dz_prev;
        q_prev   = QUOCIENTE;
        r_prev   = RESTO;
        dz_prev  = DIV_ZERO;
        A        = a;
        B        = b;
        START    = 1'b1;
        @(negedge clk);
        START    = 1'b0;
        A        = ~a;
        B        = b ^ 16'h5A5A;
        cyc      = 1;
        busy_cnt = 0;
        seen     = 1'b0;
        stable   = 1'b1;
        while (cyc <= 40 && !seen) begin
            if (DONE === 1'b1) begin
                seen = 1'b1;
            end else begin
                if (BUSY === 1'b1) busy_cnt++;
                if (QUOCIENTE !== q_prev || RESTO !== r_prev || DIV_ZERO !== dz_prev)
                    stable = 1'b0;
                @(negedge clk);
                cyc++;
            end
        end
        check({name, " latency"}, cyc, (b == 16'd0) ? 1 : 17);
        check({name, " busy_cycles"}, busy_cnt, (b == 16'd0) ? 0 : 16);
        check({name, " stable_before_done"}, {31'd0, stable}, 32'd1);
        check({name, " quotient"}, {16'd0, QUOCIENTE}, {16'd0, eq});
        check({name, " remainder"}, {16'd0, RESTO}, {16'd0, er});
        check({name, " div_zero"}, {31'd0, DIV_ZERO}, {31'd0, edz});
        @(negedge clk);
        check({name, " done_width"}, {31'd0, DONE}, 32'd0);
    endtask

    vec_t vecs[9];

    initial begin
        int n;
        int n2;
        int pulses;
        logic [15:0] ra;
        logic [15:0] rb;
        logic [15:0] rq;
        logic [15:0] rr;

        vecs[0] = '{a: 16'd1000,  b: 16'd7,      q: 16'd142,    r: 16'd6,      dz: 1'b0};
        vecs[1] = '{a: 16'hFFFF,  b: 16'd1,      q: 16'hFFFF,   r: 16'd0,      dz: 1'b0};
        vecs[2] = '{a: 16'hFFFF,  b: 16'hFFFF,   q: 16'd1,      r: 16'd0,      dz: 1'b0};
        vecs[3] = '{a: 16'd5,     b: 16'd10,     q: 16'd0,      r: 16'd5,      dz: 1'b0};
        vecs[4] = '{a: 16'h1234,  b: 16'd0,      q: 16'hFFFF,   r: 16'h1234,   dz: 1'b1};
        vecs[5] = '{a: 16'd9,     b: 16'd3,      q: 16'd3,      r: 16'd0,      dz: 1'b0};
        vecs[6] = '{a: 16'd0,     b: 16'd5,      q: 16'd0,      r: 16'd0,      dz: 1'b0};
        vecs[7] = '{a: 16'd0,     b: 16'd0,      q: 16'hFFFF,   r: 16'd0,      dz: 1'b1};
        vecs[8] = '{a: 16'hFFFE,  b: 16'h8000,   q: 16'd1,      r: 16'h7FFE,   dz: 1'b0};

        rst_n = 1'b0;
        START = 1'b0;
        A     = 16'd0;
        B     = 16'd0;
        repeat (3) @(negedge clk);
        check("reset quotient", {16'd0, QUOCIENTE}, 32'd0);
        check("reset remainder", {16'd0, RESTO}, 32'd0);
        check("reset busy", {31'd0, BUSY}, 32'd0);
        check("reset done", {31'd0, DONE}, 32'd0);
        check("reset div_zero", {31'd0, DIV_ZERO}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dz);
        end

        // START held high across two operations; operands change mid-CALC.
        A     = 16'd100;
        B     = 16'd9;
        START = 1'b1;
        repeat (5) @(negedge clk);
        A = 16'd50;
        B = 16'd5;
        wait_done(40, n);
        check("held first latency", 5 + n, 17);
        check("held first quotient", {16'd0, QUOCIENTE}, 32'd11);
        check("held first remainder", {16'd0, RESTO}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        START = 1'b0;
        wait_done(40, n2);
        check("held done spacing", 2 + n2, 18);
        check("held second quotient", {16'd0, QUOCIENTE}, 32'd10);
        check("held second remainder", {16'd0, RESTO}, 32'd0);
        repeat (3) @(negedge clk);
        check("held no third op", {31'd0, BUSY}, 32'd0);

        // Reset during the 8th CALC cycle aborts without a DONE.
        do_op("pre_reset", 16'd9, 16'd3, 16'd3, 16'd0, 1'b0);
        A     = 16'd1000;
        B     = 16'd7;
        START = 1'b1;
        @(negedge clk);
        START = 1'b0;
        repeat (7) @(negedge clk);
        check("abort busy before reset", {31'd0, BUSY}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort busy", {31'd0, BUSY}, 32'd0);
        check("abort done", {31'd0, DONE}, 32'd0);
        check("abort quotient", {16'd0, QUOCIENTE}, 32'd0);
        check("abort remainder", {16'd0, RESTO}, 32'd0);
        pulses = 0;
        repeat (25) begin
            @(negedge clk);
            if (DONE === 1'b1) pulses++;
        end
        check("abort no done", pulses, 0);
        do_op("after_reset", 16'd1000, 16'd7, 16'd142, 16'd6, 1'b0);

        for (int k = 0; k < 2000; k++) begin
            ra = 16'($urandom_range(16'hFFFF, 0));
            if (k % 2 == 0) rb = 16'($urandom_range(16'hFFFF, 1));
            else            rb = 16'($urandom_range(255, 1));
            rq = ra / rb;
            rr = ra % rb;
            do_op("sweep", ra, rb, rq, rr, 1'b0);
            check("sweep invariant", (QUOCIENTE * rb) + RESTO, {16'd0, ra});
            check("sweep rem_below_divisor", {31'd0, (RESTO < rb)}, 32'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
